// File: rtl/tdpr_mem.sv
// -----------------------------------------------------------------------------
// tdpr_mem -- true dual-port RAM with self-clearing start-up and clear request.
//
// After reset (or a clr_req accepted in READY) the block walks every word and
// writes zero, holding busy high for RAM_SIZE cycles. While busy, both ports
// are ignored. In READY each port performs one read or write per cycle with a
// registered dout and a one-cycle vld pulse. A same-address write/write lets
// port A win and pulses coll in the following cycle.
//
// Parameters:
//   ADDR_SIZE  address width per port
//   DATA_SIZE  data width per port
//   RAM_SIZE   number of words (defaults to 1<<ADDR_SIZE)
//   WR_MODE    0 = read-first (old data on dout), 1 = write-first (new data)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   clr_req               request full clear (honoured in READY only)
//   en_x, we_x            port enable, write enable (x = a, b)
//   addr_x, din_x         word address, write data
//   dout_x, vld_x         registered read data, dout-updated strobe
//   busy                  clear in progress
//   coll                  same-address write/write collision pulse
//
// Build option: define TDPR_MEM_OUTREG_EN to add one more register stage on
// dout/vld/coll of both ports (latency becomes 2 cycles).
// -----------------------------------------------------------------------------
module tdpr_mem #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int RAM_SIZE  = 1 << ADDR_SIZE,
  parameter int WR_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  input  logic                 en_a,
  input  logic                 we_a,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [DATA_SIZE-1:0] din_a,
  input  logic                 en_b,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [DATA_SIZE-1:0] din_b,
  output logic [DATA_SIZE-1:0] dout_a,
  output logic [DATA_SIZE-1:0] dout_b,
  output logic                 vld_a,
  output logic                 vld_b,
  output logic                 busy,
  output logic                 coll
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Counter is one bit wider than the address so the terminal compare never wraps.
  localparam logic [ADDR_SIZE:0] CLR_LAST    = (ADDR_SIZE + 1)'(RAM_SIZE - 1);
  localparam logic [ADDR_SIZE:0] CLR_ZERO    = {(ADDR_SIZE + 1){1'b0}};
  localparam logic [ADDR_SIZE:0] CLR_ONE     = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam bit                 WRITE_FIRST = (WR_MODE != 0);

  state_e                 state_q;
  logic [ADDR_SIZE:0]     clr_cnt_q;
  logic                   busy_q;
  logic [DATA_SIZE-1:0]   mem_q [RAM_SIZE];

  logic                   ready_s;
  logic                   same_addr_s;
  logic                   wr_a_s;
  logic                   wr_b_req_s;
  logic                   wr_b_s;
  logic [DATA_SIZE-1:0]   old_a_s;
  logic [DATA_SIZE-1:0]   old_b_s;
  logic [DATA_SIZE-1:0]   new_a_s;
  logic [DATA_SIZE-1:0]   new_b_s;

  logic [DATA_SIZE-1:0]   dout_a_d, dout_b_d;
  logic                   vld_a_d, vld_b_d, coll_d;
  logic [DATA_SIZE-1:0]   dout_a_q, dout_b_q;
  logic                   vld_a_q, vld_b_q, coll_q;

  // Port qualification, collision detect and read-data selection.
  always_comb begin
    ready_s     = (state_q == ST_READY);
    same_addr_s = (addr_a == addr_b);
    wr_a_s      = ready_s & en_a & we_a;
    wr_b_req_s  = ready_s & en_b & we_b;
    coll_d      = wr_a_s & wr_b_req_s & same_addr_s;
    // Port B's write is dropped on a collision so port A's data lands.
    wr_b_s      = wr_b_req_s & ~coll_d;
    old_a_s     = mem_q[addr_a];
    old_b_s     = mem_q[addr_b];

    // Word content after this edge, seen from each port's address.
    if (wr_a_s) begin
      new_a_s = din_a;
    end else if (wr_b_s && same_addr_s) begin
      new_a_s = din_b;
    end else begin
      new_a_s = old_a_s;
    end
    if (wr_a_s && same_addr_s) begin
      new_b_s = din_a;
    end else if (wr_b_s) begin
      new_b_s = din_b;
    end else begin
      new_b_s = old_b_s;
    end

    vld_a_d = ready_s & en_a;
    vld_b_d = ready_s & en_b;
    if (vld_a_d) begin
      dout_a_d = WRITE_FIRST ? new_a_s : old_a_s;
    end else begin
      dout_a_d = dout_a_q;
    end
    if (vld_b_d) begin
      dout_b_d = WRITE_FIRST ? new_b_s : old_b_s;
    end else begin
      dout_b_d = dout_b_q;
    end
  end

  // Clear/ready sequencer with its registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= CLR_ZERO;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= ST_READY;
            clr_cnt_q <= CLR_ZERO;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_ONE;
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= CLR_ZERO;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= CLR_ZERO;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: zero-fill while clearing, otherwise port writes.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q[ADDR_SIZE-1:0]] <= {DATA_SIZE{1'b0}};
    end else begin
      if (wr_a_s) begin
        mem_q[addr_a] <= din_a;
      end
      if (wr_b_s) begin
        mem_q[addr_b] <= din_b;
      end
    end
  end

  // First output register stage for read data, strobes and collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= {DATA_SIZE{1'b0}};
      dout_b_q <= {DATA_SIZE{1'b0}};
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      coll_q   <= coll_d;
    end
  end

`ifdef TDPR_MEM_OUTREG_EN
  logic [DATA_SIZE-1:0] dout_a_p_q, dout_b_p_q;
  logic                 vld_a_p_q, vld_b_p_q, coll_p_q;

  // Extra pipeline stage on every port-facing output except busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_p_q <= {DATA_SIZE{1'b0}};
      dout_b_p_q <= {DATA_SIZE{1'b0}};
      vld_a_p_q  <= 1'b0;
      vld_b_p_q  <= 1'b0;
      coll_p_q   <= 1'b0;
    end else begin
      dout_a_p_q <= dout_a_q;
      dout_b_p_q <= dout_b_q;
      vld_a_p_q  <= vld_a_q;
      vld_b_p_q  <= vld_b_q;
      coll_p_q   <= coll_q;
    end
  end

  assign dout_a = dout_a_p_q;
  assign dout_b = dout_b_p_q;
  assign vld_a  = vld_a_p_q;
  assign vld_b  = vld_b_p_q;
  assign coll   = coll_p_q;
`else
  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
  assign vld_a  = vld_a_q;
  assign vld_b  = vld_b_q;
  assign coll   = coll_q;
`endif

  assign busy = busy_q;

endmodule

// File: tb/tb_tdpr_mem.sv
// -----------------------------------------------------------------------------
// tb_tdpr_mem -- self-checking bench for tdpr_mem.
// Two instances (read-first and write-first) share one stimulus stream and are
// compared every cycle against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_tdpr_mem;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RAM = 256;
`ifdef TDPR_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          clr_req = 1'b0;
  logic          en_a    = 1'b0;
  logic          we_a    = 1'b0;
  logic [AW-1:0] addr_a  = 8'h00;
  logic [DW-1:0] din_a   = 8'h00;
  logic          en_b    = 1'b0;
  logic          we_b    = 1'b0;
  logic [AW-1:0] addr_b  = 8'h00;
  logic [DW-1:0] din_b   = 8'h00;

  logic [DW-1:0] dout_a_0, dout_b_0, dout_a_1, dout_b_1;
  logic          vld_a_0, vld_b_0, busy_0, coll_0;
  logic          vld_a_1, vld_b_1, busy_1, coll_1;

  tdpr_mem #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RAM_SIZE(RAM), .WR_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a_0), .dout_b(dout_b_0), .vld_a(vld_a_0), .vld_b(vld_b_0),
    .busy(busy_0), .coll(coll_0)
  );

  tdpr_mem #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RAM_SIZE(RAM), .WR_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a_1), .dout_b(dout_b_1), .vld_a(vld_a_1), .vld_b(vld_b_1),
    .busy(busy_1), .coll(coll_1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: word array, remaining clear cycles, and expected outputs
  // per mode (index 0 = read-first, 1 = write-first).
  logic [DW-1:0] mmem [RAM];
  int            clr_left;
  logic [DW-1:0] s1_da [2];
  logic [DW-1:0] s1_db [2];
  logic [DW-1:0] eo_da [2];
  logic [DW-1:0] eo_db [2];
  logic          s1_va, s1_vb, s1_coll, eo_va, eo_vb, eo_coll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = RAM;
    for (int i = 0; i < RAM; i++) mmem[i] = 8'h00;
    for (int m = 0; m < 2; m++) begin
      s1_da[m] = 8'h00; s1_db[m] = 8'h00; eo_da[m] = 8'h00; eo_db[m] = 8'h00;
    end
    s1_va = 1'b0; s1_vb = 1'b0; s1_coll = 1'b0;
    eo_va = 1'b0; eo_vb = 1'b0; eo_coll = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [DW-1:0] oa, ob;
    logic          wa, wb;
    if (LAT == 2) begin
      eo_da = s1_da; eo_db = s1_db; eo_va = s1_va; eo_vb = s1_vb; eo_coll = s1_coll;
    end
    if (clr_left > 0) begin
      clr_left--;
      s1_va = 1'b0; s1_vb = 1'b0; s1_coll = 1'b0;
    end else begin
      wa = en_a & we_a;
      wb = en_b & we_b;
      oa = mmem[addr_a];
      ob = mmem[addr_b];
      if (wb) mmem[addr_b] = din_b;
      if (wa) mmem[addr_a] = din_a;   // applied last so port A wins
      if (en_a) begin s1_da[0] = oa; s1_da[1] = mmem[addr_a]; end
      if (en_b) begin s1_db[0] = ob; s1_db[1] = mmem[addr_b]; end
      s1_va   = en_a;
      s1_vb   = en_b;
      s1_coll = wa & wb & (addr_a == addr_b);
      if (clr_req) begin
        clr_left = RAM;
        for (int i = 0; i < RAM; i++) mmem[i] = 8'h00;
      end
    end
    if (LAT == 1) begin
      eo_da = s1_da; eo_db = s1_db; eo_va = s1_va; eo_vb = s1_vb; eo_coll = s1_coll;
    end
  endtask

  task automatic check_all();
    chk("busy_m0",   32'(busy_0),   32'(clr_left > 0));
    chk("busy_m1",   32'(busy_1),   32'(clr_left > 0));
    chk("dout_a_m0", 32'(dout_a_0), 32'(eo_da[0]));
    chk("dout_b_m0", 32'(dout_b_0), 32'(eo_db[0]));
    chk("dout_a_m1", 32'(dout_a_1), 32'(eo_da[1]));
    chk("dout_b_m1", 32'(dout_b_1), 32'(eo_db[1]));
    chk("vld_a_m0",  32'(vld_a_0),  32'(eo_va));
    chk("vld_b_m0",  32'(vld_b_0),  32'(eo_vb));
    chk("vld_a_m1",  32'(vld_a_1),  32'(eo_va));
    chk("vld_b_m1",  32'(vld_b_1),  32'(eo_vb));
    chk("coll_m0",   32'(coll_0),   32'(eo_coll));
    chk("coll_m1",   32'(coll_1),   32'(eo_coll));
  endtask

  // One clock: inputs are already stable (driven at the falling edge).
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic settle();
    idle();
    repeat (LAT - 1) step();
  endtask

  task automatic rand_inputs(input int max_addr, input int clr_odds);
    en_a    = 1'($urandom_range(0, 1));
    we_a    = 1'($urandom_range(0, 1));
    en_b    = 1'($urandom_range(0, 1));
    we_b    = 1'($urandom_range(0, 1));
    addr_a  = 8'($urandom_range(0, max_addr));
    addr_b  = 8'($urandom_range(0, max_addr));
    din_a   = 8'($urandom);
    din_b   = 8'($urandom);
    clr_req = ($urandom_range(0, clr_odds) == 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random accesses while busy; returns cycles until busy drops (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      rand_inputs(255, 3);
      step();
      n++;
    end while (busy_0 && n < 1000);
    idle();
  endtask

  task automatic wr(input logic port_b, input logic [7:0] a, input logic [7:0] d);
    if (port_b) begin en_b = 1'b1; we_b = 1'b1; addr_b = a; din_b = d; end
    else begin en_a = 1'b1; we_a = 1'b1; addr_a = a; din_a = d; end
  endtask

  task automatic rd(input logic port_b, input logic [7:0] a);
    if (port_b) begin en_b = 1'b1; we_b = 1'b0; addr_b = a; end
    else begin en_a = 1'b1; we_a = 1'b0; addr_a = a; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    @(negedge clk);

    // Reset release, clear length, then read of a cleared word.
    do_reset();
    wait_ready(n);
    chk("busy_len_reset", 32'(n), 32'd256);
    idle(); rd(1'b0, 8'h37); step(); settle();
    chk("rd37_dout", 32'(dout_a_0), 32'h00);
    chk("rd37_vld",  32'(vld_a_0),  32'd1);

    // Write then read back on port A.
    idle(); wr(1'b0, 8'h01, 8'hA1); step();
    idle(); rd(1'b0, 8'h01); step(); settle();
    chk("rdA1_m0", 32'(dout_a_0), 32'hA1);
    chk("rdA1_m1", 32'(dout_a_1), 32'hA1);

    // Cross-port read-during-write.
    idle(); wr(1'b0, 8'h10, 8'h55); step();
    idle(); wr(1'b0, 8'h10, 8'h16); rd(1'b1, 8'h10); step(); settle();
    chk("rdw_m0", 32'(dout_b_0), 32'h55);
    chk("rdw_m1", 32'(dout_b_1), 32'h16);

    // Write/write collision.
    idle(); wr(1'b0, 8'h11, 8'h16); wr(1'b1, 8'h11, 8'hBB); step(); settle();
    chk("coll_pulse", 32'(coll_0), 32'd1);
    idle(); rd(1'b1, 8'h11); step(); settle();
    chk("coll_winner", 32'(dout_b_1), 32'h16);

    // Clear request with ignored accesses while busy.
    idle(); wr(1'b0, 8'hFE, 8'hFF); step();
    idle(); clr_req = 1'b1; step();
    chk("clr_busy", 32'(busy_0), 32'd1);
    wait_ready(n);
    chk("busy_len_clr", 32'(n), 32'd256);
    idle(); rd(1'b0, 8'hFE); step(); settle();
    chk("rdFE_m1", 32'(dout_a_1), 32'h00);

    // Reset asserted mid-clear restarts the full clear.
    idle(); clr_req = 1'b1; step();
    repeat (100) begin rand_inputs(255, 3); step(); end
    #2;
    do_reset();
    wait_ready(n);
    chk("busy_len_midrst", 32'(n), 32'd256);

    // Random traffic on a small address window to provoke collisions.
    repeat (600) begin rand_inputs(15, 299); step(); end
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tdpr_mem.md
TDPR_MEM -- requirements
Module: tdpr_mem

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- ADDR_SIZE, 8, address width per port.
- DATA_SIZE, 8, data width per port.
- RAM_SIZE, 1<<ADDR_SIZE, number of words.
- WR_MODE, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).

REQ-002 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clr_req, in, 1, request a full memory clear (sampled in READY only).
- en_a / en_b, in, 1, port enable.
- we_a / we_b, in, 1, write enable; qualified by en.
- addr_a / addr_b, in, ADDR_SIZE, word address.
- din_a / din_b, in, DATA_SIZE, write data.
- dout_a / dout_b, out, DATA_SIZE, registered read data.
- vld_a / vld_b, out, 1, dout updated this cycle.
- busy, out, 1, clear in progress; port accesses are ignored.
- coll, out, 1, one-cycle pulse on a same-address write/write collision.

Function
REQ-003 The FSM SHALL have two states: CLEAR and READY.
- CLEAR writes 0 to address clr_cnt and increments clr_cnt each cycle.
- CLEAR exits to READY in the cycle after clr_cnt = RAM_SIZE-1 is written, i.e. RAM_SIZE cycles in total.
- READY with clr_req=1 returns to CLEAR with clr_cnt=0.
REQ-004 busy SHALL be 1 exactly while in CLEAR.
- en/we on both ports SHALL be ignored while busy: no write, no vld.
- clr_req SHALL be ignored while busy.
REQ-005 A read (en=1, we=0) SHALL have 1-cycle latency: dout loads mem[addr] and vld pulses 1 for one cycle.
REQ-006 A write (en=1, we=1) SHALL store din at the edge.
- vld pulses 1.
- dout shows din when WR_MODE=1, or the old mem[addr] when WR_MODE=0.
REQ-007 When en=0, dout SHALL hold its last value and vld SHALL be 0.
REQ-008 Cross-port read-during-write (one port writes, the other reads the same address in the same cycle):
- the reading port SHALL return old data when WR_MODE=0 and new data when WR_MODE=1.
- coll SHALL stay 0.
REQ-009 Write/write collision (both ports write the same address in the same cycle):
- port A data SHALL win.
- coll SHALL pulse 1 in the following cycle.
- both dout SHALL follow REQ-006 using port A data as the "new" value.
REQ-010 Writes to different addresses SHALL complete independently in the same cycle.
REQ-011 clr_cnt SHALL be ADDR_SIZE+1 bits wide so the terminal compare does not wrap at RAM_SIZE-1.

Reset
REQ-012 While rst_n=0, the outputs SHALL be:
- dout_a, dout_b = 0
- vld_a, vld_b, coll = 0
- busy = 1
- state = CLEAR, clr_cnt = 0
REQ-013 After rst_n deasserts, the memory SHALL be cleared per REQ-003 before any port access takes effect.
REQ-014 Reset asserted mid-clear or mid-access SHALL restart the clear from address 0.
- An in-flight write at the reset edge is not guaranteed to land.

Configuration
REQ-015 Macro TDPR_MEM_OUTREG_EN SHALL select the read-path pipelining.
- Defined: an additional output register stage is inserted on dout and vld of both ports, so read/write latency is 2 cycles and coll is also delayed by one cycle.
- Undefined: latency is exactly as in REQ-005 to REQ-009.

Verification (default parameters, TDPR_MEM_OUTREG_EN undefined unless stated)
REQ-016 The bench SHALL cover these directed scenarios:
- Reset release: busy=1 for 256 cycles then 0; afterwards a read of addr 0x37 -> dout=0x00, vld pulse.
- A writes 0xA1 to 0x01, next cycle A reads 0x01 -> dout_a=0xA1 one cycle after the read.
- WR_MODE=0 and WR_MODE=1, mem[0x10]=0x55: A writes 0x16 to 0x10 while B reads 0x10 -> dout_b=0x55 (mode 0) or 0x16 (mode 1).
- Both ports write 0x11 (A=0x16, B=0xBB) -> coll=1 next cycle; a later read of 0x11 returns 0x16.
- After writing 0xFF to 0xFE, pulse clr_req -> busy high 256 cycles; accesses during busy are ignored (vld=0); a later read of 0xFE returns 0x00.
- With TDPR_MEM_OUTREG_EN defined, repeat scenario 2 -> dout_a=0xA1 two cycles after the read; reset asserted mid-clear restarts busy for a full 256 cycles.
